// File: rtl/event_proc_scheduler_if.sv
// event_proc_scheduler_if: config, event, dispatch and status signals of the event scheduler
interface event_proc_scheduler_if #(
  parameter int NPROC = 4,
  parameter int CNTW = 8,
  parameter int IDW = $clog2(NPROC)
);
  logic             cfg_we;
  logic [IDW-1:0]   cfg_idx;
  logic [1:0]       cfg_mode;
  logic [CNTW-1:0]  cfg_count;
  logic             cfg_err;
  logic [NPROC-1:0] evt;
  logic             grant_valid;
  logic [IDW-1:0]   grant_id;
  logic             grant_ready;
  logic             exec_done;
  logic [NPROC-1:0] slot_done;
  logic             idle;
  modport master (
    output cfg_we, cfg_idx, cfg_mode, cfg_count, evt, grant_ready, exec_done,
    input  cfg_err, grant_valid, grant_id, slot_done, idle
  );
  modport slave (
    input  cfg_we, cfg_idx, cfg_mode, cfg_count, evt, grant_ready, exec_done,
    output cfg_err, grant_valid, grant_id, slot_done, idle
  );
endinterface

// File: rtl/event_proc_scheduler.sv
// event_proc_scheduler: round-robin dispatch of event-triggered process slots onto one execution unit
module event_proc_scheduler #(
  parameter int NPROC = 4,
  parameter int CNTW = 8,
  parameter int IDW = $clog2(NPROC)
) (
  input logic clk,
  input logic rst,
  event_proc_scheduler_if.slave bus
);
  typedef enum logic [1:0] {SL_IDLE, SL_ARMED, SL_PEND, SL_RUN} slot_t;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} fsm_t;
  slot_t            st_q [NPROC];
  slot_t            st_d [NPROC];
  logic [1:0]       mode_q [NPROC];
  logic [1:0]       mode_d [NPROC];
  logic [CNTW-1:0]  cnt_q [NPROC];
  logic [CNTW-1:0]  cnt_d [NPROC];
  logic [NPROC-1:0] rt_q, rt_d, done_q, done_d, pend;
  fsm_t             fsm_q, fsm_d;
  logic [IDW-1:0]   gid_q, gid_d, rr_q, rr_d, sel;
  logic             cfg_err_q, cfg_err_d, cfg_rej, cfg_ok, busy, found, last;
  always_comb begin
    cfg_rej = bus.cfg_we && (st_q[bus.cfg_idx] == SL_RUN || (fsm_q == S_ISSUE && gid_q == bus.cfg_idx));
    cfg_ok = bus.cfg_we && !cfg_rej;
    cfg_err_d = cfg_rej;
    busy = 1'b0;
    pend = '0;
    for (int i = 0; i < NPROC; i++) begin
      pend[i] = st_q[i] == SL_PEND && !(cfg_ok && bus.cfg_idx == IDW'(i));
      busy = busy || st_q[i] == SL_PEND || st_q[i] == SL_RUN;
    end
  end
  always_comb begin
    done_d = '0;
    rt_d = rt_q;
    last = 1'b0;
    for (int i = 0; i < NPROC; i++) begin
      st_d[i] = st_q[i];
      mode_d[i] = mode_q[i];
      cnt_d[i] = cnt_q[i];
      last = !(mode_q[i] == 2'd2 || (mode_q[i] == 2'd3 && cnt_q[i] != CNTW'(1)));
      case (st_q[i])
        SL_ARMED: if (bus.evt[i]) st_d[i] = SL_PEND;
        SL_PEND: if (fsm_q == S_ISSUE && gid_q == IDW'(i) && bus.grant_ready) st_d[i] = SL_RUN;
        SL_RUN:
          if (fsm_q == S_WAIT && bus.exec_done) begin
            st_d[i] = last ? SL_IDLE : (rt_q[i] || bus.evt[i]) ? SL_PEND : SL_ARMED;
            cnt_d[i] = mode_q[i] == 2'd3 ? cnt_q[i] - 1'b1 : cnt_q[i];
            rt_d[i] = 1'b0;
            done_d[i] = last;
          end else if (bus.evt[i]) rt_d[i] = 1'b1;
        default: ;
      endcase
      if (cfg_ok && bus.cfg_idx == IDW'(i)) begin
        mode_d[i] = bus.cfg_mode;
        cnt_d[i] = bus.cfg_count == '0 ? CNTW'(1) : bus.cfg_count;
        rt_d[i] = 1'b0;
        st_d[i] = bus.cfg_mode != 2'd0 ? SL_ARMED : SL_IDLE;
      end
    end
  end
  always_comb begin
    fsm_d = fsm_q;
    gid_d = gid_q;
    rr_d = rr_q;
    sel = '0;
    found = 1'b0;
    for (int k = NPROC - 1; k >= 0; k--)
      if (pend[(int'(rr_q) + k) % NPROC]) begin
        found = 1'b1;
        sel = IDW'((int'(rr_q) + k) % NPROC);
      end
    case (fsm_q)
      S_IDLE:
        if (found) begin
          fsm_d = S_ISSUE;
          gid_d = sel;
        end
      S_ISSUE:
        if (bus.grant_ready) begin
          fsm_d = S_WAIT;
          rr_d = gid_q == IDW'(NPROC - 1) ? '0 : gid_q + 1'b1;
        end
      S_WAIT: if (bus.exec_done) fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NPROC; i++) begin
        st_q[i] <= SL_IDLE;
        mode_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      rt_q <= '0;
      done_q <= '0;
      fsm_q <= S_IDLE;
      gid_q <= '0;
      rr_q <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      st_q <= st_d;
      mode_q <= mode_d;
      cnt_q <= cnt_d;
      rt_q <= rt_d;
      done_q <= done_d;
      fsm_q <= fsm_d;
      gid_q <= gid_d;
      rr_q <= rr_d;
      cfg_err_q <= cfg_err_d;
    end
  end
  assign bus.grant_valid = fsm_q == S_ISSUE;
  assign bus.grant_id = gid_q;
  assign bus.cfg_err = cfg_err_q;
  assign bus.slot_done = done_q;
  assign bus.idle = fsm_q == S_IDLE && !busy;
endmodule

// File: tb/tb_event_proc_scheduler.sv
// tb_event_proc_scheduler: directed scenario tests of the round-robin event scheduler
module tb_event_proc_scheduler;
  localparam int NPROC = 4;
  localparam int CNTW = 8;
  localparam int IDW = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  event_proc_scheduler_if #(.NPROC(NPROC), .CNTW(CNTW), .IDW(IDW)) bus ();
  event_proc_scheduler #(.NPROC(NPROC), .CNTW(CNTW), .IDW(IDW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  task automatic cfg(input int idx, input int mode, input int cnt);
    bus.cfg_we = 1'b1;
    bus.cfg_idx = IDW'(idx);
    bus.cfg_mode = 2'(mode);
    bus.cfg_count = CNTW'(cnt);
    step();
    bus.cfg_we = 1'b0;
  endtask
  task automatic pulse_evt(input logic [NPROC-1:0] v);
    bus.evt = v;
    step();
    bus.evt = '0;
  endtask
  task automatic wait_grant(input string name);
    bit ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      if (bus.grant_valid) ok = 1'b1;
      else step();
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL %s grant_valid got 0 exp 1 within 20 cycles", name); end
  endtask
  task automatic run_one();
    bus.grant_ready = 1'b1;
    step();
    bus.grant_ready = 1'b0;
    bus.exec_done = 1'b1;
    step();
    bus.exec_done = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++; if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL rst_gv got %b exp 0", bus.grant_valid); end
    checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL rst_gid got %0d exp 0", bus.grant_id); end
    checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL rst_cfg_err got %b exp 0", bus.cfg_err); end
    checks++; if (bus.slot_done !== 4'b0000) begin errors++; $display("FAIL rst_slot_done got %b exp 0000", bus.slot_done); end
    checks++; if (bus.idle !== 1'b1) begin errors++; $display("FAIL rst_idle got %b exp 1", bus.idle); end
  endtask
  task automatic test_once();
    cfg(2, 1, 0);
    checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL t1_cfg_err got %b exp 0", bus.cfg_err); end
    pulse_evt(4'b0100);
    checks++; if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL t1_gv_early got %b exp 0", bus.grant_valid); end
    step();
    checks++; if (bus.grant_valid !== 1'b1) begin errors++; $display("FAIL t1_gv got %b exp 1", bus.grant_valid); end
    checks++; if (bus.grant_id !== 2'd2) begin errors++; $display("FAIL t1_gid got %0d exp 2", bus.grant_id); end
    bus.grant_ready = 1'b1;
    step();
    bus.grant_ready = 1'b0;
    checks++; if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL t1_gv_wait got %b exp 0", bus.grant_valid); end
    step();
    checks++; if (bus.idle !== 1'b0) begin errors++; $display("FAIL t1_idle_busy got %b exp 0", bus.idle); end
    step();
    bus.exec_done = 1'b1;
    step();
    bus.exec_done = 1'b0;
    checks++; if (bus.slot_done !== 4'b0100) begin errors++; $display("FAIL t1_slot_done got %b exp 0100", bus.slot_done); end
    checks++; if (bus.idle !== 1'b1) begin errors++; $display("FAIL t1_idle got %b exp 1", bus.idle); end
    step();
    checks++; if (bus.slot_done !== 4'b0000) begin errors++; $display("FAIL t1_done_pulse got %b exp 0000", bus.slot_done); end
    pulse_evt(4'b0100);
    step();
    step();
    checks++; if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL t1_retired_gv got %b exp 0", bus.grant_valid); end
  endtask
  task automatic test_round_robin();
    do_reset();
    for (int s = 0; s < NPROC; s++) cfg(s, 2, 0);
    bus.grant_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      pulse_evt(4'b1111);
      for (int g = 0; g < NPROC; g++) begin
        wait_grant("t2_wait");
        checks++; if (bus.grant_id !== IDW'(g)) begin errors++; $display("FAIL t2_order round %0d pos %0d got %0d exp %0d", r, g, bus.grant_id, g); end
        step();
        bus.exec_done = 1'b1;
        step();
        bus.exec_done = 1'b0;
      end
      step();
      checks++; if (bus.idle !== 1'b1) begin errors++; $display("FAIL t2_idle round %0d got %b exp 1", r, bus.idle); end
    end
    bus.grant_ready = 1'b0;
  endtask
  task automatic test_count();
    do_reset();
    cfg(1, 3, 3);
    for (int it = 1; it <= 3; it++) begin
      pulse_evt(4'b0010);
      wait_grant("t3_wait");
      checks++; if (bus.grant_id !== 2'd1) begin errors++; $display("FAIL t3_gid iter %0d got %0d exp 1", it, bus.grant_id); end
      run_one();
      checks++; if (bus.slot_done !== (it == 3 ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL t3_done iter %0d got %b exp %b", it, bus.slot_done, it == 3 ? 4'b0010 : 4'b0000); end
    end
    pulse_evt(4'b0010);
    step();
    step();
    checks++; if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL t3_fourth_gv got %b exp 0", bus.grant_valid); end
    cfg(1, 3, 0);
    pulse_evt(4'b0010);
    wait_grant("t3_zero_wait");
    run_one();
    checks++; if (bus.slot_done !== 4'b0010) begin errors++; $display("FAIL t3_zero_done got %b exp 0010", bus.slot_done); end
  endtask
  task automatic test_retrigger();
    bit extra = 1'b0;
    do_reset();
    cfg(0, 2, 0);
    pulse_evt(4'b0001);
    wait_grant("t4_wait");
    bus.grant_ready = 1'b1;
    step();
    bus.grant_ready = 1'b0;
    pulse_evt(4'b0001);
    pulse_evt(4'b0001);
    cfg(0, 1, 0);
    checks++; if (bus.cfg_err !== 1'b1) begin errors++; $display("FAIL t4_cfg_err got %b exp 1", bus.cfg_err); end
    step();
    checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL t4_cfg_err_pulse got %b exp 0", bus.cfg_err); end
    bus.exec_done = 1'b1;
    step();
    bus.exec_done = 1'b0;
    checks++; if (bus.slot_done !== 4'b0000) begin errors++; $display("FAIL t4_done1 got %b exp 0000", bus.slot_done); end
    wait_grant("t4_regrant");
    checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL t4_regrant_id got %0d exp 0", bus.grant_id); end
    run_one();
    checks++; if (bus.slot_done !== 4'b0000) begin errors++; $display("FAIL t4_mode_kept got %b exp 0000", bus.slot_done); end
    for (int n = 0; n < 6; n++) begin
      step();
      if (bus.grant_valid) extra = 1'b1;
    end
    checks++; if (extra !== 1'b0) begin errors++; $display("FAIL t4_extra_grant got %b exp 0", extra); end
  endtask
  task automatic test_backpressure();
    int bad = 0;
    do_reset();
    cfg(3, 1, 0);
    cfg(1, 1, 0);
    pulse_evt(4'b1000);
    wait_grant("t5_wait");
    checks++; if (bus.grant_id !== 2'd3) begin errors++; $display("FAIL t5_gid got %0d exp 3", bus.grant_id); end
    bus.evt = 4'b0010;
    for (int n = 0; n < 5; n++) begin
      step();
      bus.evt = '0;
      if (bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd3) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL t5_hold unstable cycles got %0d exp 0", bad); end
    bus.grant_ready = 1'b1;
    step();
    bus.grant_ready = 1'b0;
    checks++; if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL t5_accept_gv got %b exp 0", bus.grant_valid); end
    bus.exec_done = 1'b1;
    step();
    bus.exec_done = 1'b0;
    checks++; if (bus.slot_done !== 4'b1000) begin errors++; $display("FAIL t5_done3 got %b exp 1000", bus.slot_done); end
    wait_grant("t5_wait2");
    checks++; if (bus.grant_id !== 2'd1) begin errors++; $display("FAIL t5_gid2 got %0d exp 1", bus.grant_id); end
    run_one();
    checks++; if (bus.slot_done !== 4'b0010) begin errors++; $display("FAIL t5_done1 got %b exp 0010", bus.slot_done); end
  endtask
  task automatic test_reset_mid();
    bit seen = 1'b0;
    do_reset();
    cfg(2, 2, 0);
    pulse_evt(4'b0100);
    wait_grant("t6_wait");
    bus.grant_ready = 1'b1;
    step();
    bus.grant_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL t6_gv got %b exp 0", bus.grant_valid); end
    checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL t6_gid got %0d exp 0", bus.grant_id); end
    checks++; if (bus.idle !== 1'b1) begin errors++; $display("FAIL t6_idle got %b exp 1", bus.idle); end
    checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL t6_cfg_err got %b exp 0", bus.cfg_err); end
    bus.exec_done = 1'b1;
    step();
    bus.exec_done = 1'b0;
    checks++; if (bus.slot_done !== 4'b0000) begin errors++; $display("FAIL t6_slot_done got %b exp 0000", bus.slot_done); end
    bus.evt = 4'b0100;
    for (int n = 0; n < 5; n++) begin
      step();
      bus.evt = '0;
      if (bus.grant_valid || bus.slot_done != 4'b0000) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL t6_activity got %b exp 0", seen); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.cfg_we = 1'b0;
    bus.cfg_idx = '0;
    bus.cfg_mode = '0;
    bus.cfg_count = '0;
    bus.evt = '0;
    bus.grant_ready = 1'b0;
    bus.exec_done = 1'b0;
    test_reset();
    test_once();
    test_round_robin();
    test_count();
    test_retrigger();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
